// File: rtl/if_pkg.sv
// Shared fetch-stage constants and PC type, also imported by the downstream pipeline registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

  localparam int IF_WIDTH = 32;

  typedef logic [IF_WIDTH-1:0] pc_t;

  localparam pc_t IF_RESET_PC = 32'h0000_0000;
  localparam pc_t IF_PC_INCR  = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Width-parameterized register with synchronous active-low reset to a fixed value and write enable.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: en low holds q (stall).
//
// Ports:
//   clock   - rising-edge clock
//   reset_n - synchronous active-low reset, wins over en
//   en      - write enable
//   d       - next value
//   q       - registered value
module pc_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select (sequential vs redirect) and PC + PC_INCR adder.
// Latency: mux and adder combinational; PC updates 1 cycle after MuxSaida is presented.
// Backpressure: PCescreve low stalls the PC indefinitely; mux output keeps following its inputs.
//
// Optional feature macro: IF_ALIGN_CHECK_EN adds the pc_desalinhado output.
//
// Ports:
//   clock          - rising-edge clock
//   reset_n        - synchronous active-low reset, overrides PCescreve
//   entradaPC      - sequential next-PC candidate (mux input 0)
//   entradaMux     - redirect target (mux input 1)
//   controle       - mux select, 1 = redirect
//   PCescreve      - PC write enable
//   MuxSaida       - selected next PC (combinational)
//   Pcsaida        - current PC (registered)
//   saidaAdder     - Pcsaida + PC_INCR, wraps modulo 2^WIDTH
//   pc_desalinhado - PC low two bits non-zero (IF_ALIGN_CHECK_EN only)
module if_stage
  import if_pkg::*;
#(
  parameter int               WIDTH    = IF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC),
  parameter logic [WIDTH-1:0] PC_INCR  = WIDTH'(IF_PC_INCR)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] entradaPC,
  input  logic [WIDTH-1:0] entradaMux,
  input  logic             controle,
  input  logic             PCescreve,
  output logic [WIDTH-1:0] MuxSaida,
  output logic [WIDTH-1:0] Pcsaida,
  output logic [WIDTH-1:0] saidaAdder
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic             pc_desalinhado
`endif
);

  assign MuxSaida = controle ? entradaMux : entradaPC;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (PCescreve),
    .d      (MuxSaida),
    .q      (Pcsaida)
  );

  // Same-width add: carry out is dropped, so the incrementer wraps.
  assign saidaAdder = Pcsaida + PC_INCR;

`ifdef IF_ALIGN_CHECK_EN
  // Informational only; does not gate the PC update.
  assign pc_desalinhado = |Pcsaida[1:0];
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_pkg::*;

  logic  clock = 1'b0;
  logic  reset_n;
  pc_t   entradaPC;
  pc_t   entradaMux;
  logic  controle;
  logic  PCescreve;
  pc_t   MuxSaida;
  pc_t   Pcsaida;
  pc_t   saidaAdder;
`ifdef IF_ALIGN_CHECK_EN
  logic  pc_desalinhado;
`endif

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .entradaPC (entradaPC),
    .entradaMux(entradaMux),
    .controle  (controle),
    .PCescreve (PCescreve),
    .MuxSaida  (MuxSaida),
    .Pcsaida   (Pcsaida),
    .saidaAdder(saidaAdder)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .pc_desalinhado(pc_desalinhado)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    PCescreve  = 1'b1;
    controle   = 1'b1;
    entradaMux = 32'd10;
    entradaPC  = 32'd0;
    #1;
    check("mux_in_reset", MuxSaida, 32'd10);
    tick();
    check("reset_pc", Pcsaida, 32'd0);
    check("reset_adder", saidaAdder, 32'd4);
`ifdef IF_ALIGN_CHECK_EN
    check("reset_align", {31'd0, pc_desalinhado}, 32'd0);
`endif

    // Redirect
    reset_n = 1'b1;
    #1;
    check("redir_mux", MuxSaida, 32'd10);
    tick();
    check("redir_pc", Pcsaida, 32'd10);
    check("redir_adder", saidaAdder, 32'd14);
`ifdef IF_ALIGN_CHECK_EN
    check("redir_align", {31'd0, pc_desalinhado}, 32'd1);
`endif

    // Sequential
    controle  = 1'b0;
    entradaPC = 32'd4;
    #1;
    check("seq_mux", MuxSaida, 32'd4);
    tick();
    check("seq_pc", Pcsaida, 32'd4);
    check("seq_adder", saidaAdder, 32'd8);
`ifdef IF_ALIGN_CHECK_EN
    check("seq_align", {31'd0, pc_desalinhado}, 32'd0);
`endif

    // Stall for 3 edges with the redirect path selected
    PCescreve  = 1'b0;
    controle   = 1'b1;
    entradaMux = 32'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", Pcsaida, 32'd4);
      check("stall_adder", saidaAdder, 32'd8);
      check("stall_mux", MuxSaida, 32'd10);
    end

    // Wrap of the incrementer
    PCescreve = 1'b1;
    controle  = 1'b0;
    entradaPC = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc", Pcsaida, 32'hFFFF_FFFC);
    check("wrap_adder", saidaAdder, 32'd0);

    // Reset mid-operation overrides a pending write
    reset_n   = 1'b0;
    entradaPC = 32'h0000_0100;
    tick();
    check("midrst_pc", Pcsaida, 32'd0);
    check("midrst_adder", saidaAdder, 32'd4);

    // Release: write happens on the very next edge
    reset_n = 1'b1;
    tick();
    check("release_pc", Pcsaida, 32'h0000_0100);
    check("release_adder", saidaAdder, 32'h0000_0104);

    // Reset wins even while stalled, then stall holds the reset value
    PCescreve = 1'b0;
    reset_n   = 1'b0;
    tick();
    check("rst_stall_pc", Pcsaida, 32'd0);
    reset_n    = 1'b1;
    controle   = 1'b1;
    entradaMux = 32'h0000_0203;
    tick();
    check("post_rst_stall_pc", Pcsaida, 32'd0);
    check("post_rst_stall_mux", MuxSaida, 32'h0000_0203);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
